// File: rtl/multicycle_control.sv
// Multicycle MIPS control FSM: fetch/decode/execute/memory/writeback sequencing.
// Optional BNE_SUPPORT_EN adds opcode 0x05 (bne) via the BNE_EX state.
module multicycle_control (
  input  logic       clk,
  input  logic       reset,
  input  logic [5:0] Opcode,
  input  logic [5:0] Funct,
  input  logic       Zero,
  output logic [3:0] ALUOperation,
  output logic       PCEn,
  output logic [1:0] PCSrc,
  output logic       IorD,
  output logic       MemRead,
  output logic       MemWrite,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       RegDst,
  output logic       MemtoReg,
  output logic       ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic       ExtOp,
  output logic       Illegal
);

  localparam logic [3:0] ALU_AND = 4'b0000;
  localparam logic [3:0] ALU_OR  = 4'b0001;
  localparam logic [3:0] ALU_NOR = 4'b0010;
  localparam logic [3:0] ALU_ADD = 4'b0011;
  localparam logic [3:0] ALU_SUB = 4'b0100;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_ANDI = 6'h0C;
  localparam logic [5:0] OP_ORI  = 6'h0D;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_NOR = 6'h27;

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMRD    = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWR    = 4'd5;
  localparam logic [3:0] S_RTYPE_EX = 4'd6;
  localparam logic [3:0] S_RTYPE_WB = 4'd7;
  localparam logic [3:0] S_BEQ_EX   = 4'd8;
  localparam logic [3:0] S_IMM_EX   = 4'd9;
  localparam logic [3:0] S_IMM_WB   = 4'd10;
  localparam logic [3:0] S_JUMP     = 4'd11;
`ifdef BNE_SUPPORT_EN
  localparam logic [3:0] S_BNE_EX   = 4'd12;
`endif

  logic [3:0] state_q, state_d;

  logic op_mem, op_r, op_beq, op_imm, op_j, op_bne;
  logic fn_ok, dec_legal;

  assign op_mem = (Opcode == OP_LW) || (Opcode == OP_SW);
  assign op_r   = (Opcode == OP_R);
  assign op_beq = (Opcode == OP_BEQ);
  assign op_imm = (Opcode == OP_ADDI) || (Opcode == OP_ANDI)
                || (Opcode == OP_ORI);
  assign op_j   = (Opcode == OP_J);
`ifdef BNE_SUPPORT_EN
  assign op_bne = (Opcode == OP_BNE);
`else
  assign op_bne = 1'b0;
`endif

  assign fn_ok = (Funct == FN_ADD) || (Funct == FN_SUB)
               || (Funct == FN_AND) || (Funct == FN_OR)
               || (Funct == FN_NOR);

  assign dec_legal = op_mem || (op_r && fn_ok) || op_beq
                   || op_imm || op_j || op_bne;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= S_FETCH;
    else        state_q <= state_d;
  end

  always_comb begin
    state_d = S_FETCH;
    unique case (state_q)
      S_FETCH: state_d = S_DECODE;
      S_DECODE: begin
        unique case (1'b1)
          op_mem:          state_d = S_MEMADR;
          (op_r && fn_ok): state_d = S_RTYPE_EX;
          op_beq:          state_d = S_BEQ_EX;
          op_imm:          state_d = S_IMM_EX;
          op_j:            state_d = S_JUMP;
`ifdef BNE_SUPPORT_EN
          op_bne:          state_d = S_BNE_EX;
`endif
          default:         state_d = S_FETCH;
        endcase
      end
      S_MEMADR:
        state_d = (Opcode == OP_SW) ? S_MEMWR : S_MEMRD;
      S_MEMRD:    state_d = S_MEMWB;
      S_RTYPE_EX: state_d = S_RTYPE_WB;
      S_IMM_EX:   state_d = S_IMM_WB;
      default:    state_d = S_FETCH;
    endcase
  end

  always_comb begin
    ALUOperation = ALU_ADD;
    PCEn         = 1'b0;
    PCSrc        = 2'b00;
    IorD         = 1'b0;
    MemRead      = 1'b0;
    MemWrite     = 1'b0;
    IRWrite      = 1'b0;
    RegWrite     = 1'b0;
    RegDst       = 1'b0;
    MemtoReg     = 1'b0;
    ALUSrcA      = 1'b0;
    ALUSrcB      = 2'b00;
    ExtOp        = 1'b1;
    Illegal      = 1'b0;
    unique case (state_q)
      S_FETCH: begin
        MemRead = 1'b1;
        IRWrite = 1'b1;
        PCEn    = 1'b1;
        ALUSrcB = 2'b01;
      end
      S_DECODE: begin
        ALUSrcB = 2'b11;
        Illegal = !dec_legal;
      end
      S_MEMADR: begin
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
      end
      S_MEMRD: begin
        IorD    = 1'b1;
        MemRead = 1'b1;
      end
      S_MEMWB: begin
        RegWrite = 1'b1;
        MemtoReg = 1'b1;
      end
      S_MEMWR: begin
        IorD     = 1'b1;
        MemWrite = 1'b1;
      end
      S_RTYPE_EX: begin
        ALUSrcA = 1'b1;
        unique case (Funct)
          FN_SUB:  ALUOperation = ALU_SUB;
          FN_AND:  ALUOperation = ALU_AND;
          FN_OR:   ALUOperation = ALU_OR;
          FN_NOR:  ALUOperation = ALU_NOR;
          default: ALUOperation = ALU_ADD;
        endcase
      end
      S_RTYPE_WB: begin
        RegWrite = 1'b1;
        RegDst   = 1'b1;
      end
      S_BEQ_EX: begin
        ALUSrcA      = 1'b1;
        ALUOperation = ALU_SUB;
        PCSrc        = 2'b01;
        PCEn         = Zero;
      end
`ifdef BNE_SUPPORT_EN
      S_BNE_EX: begin
        ALUSrcA      = 1'b1;
        ALUOperation = ALU_SUB;
        PCSrc        = 2'b01;
        PCEn         = !Zero;
      end
`endif
      S_IMM_EX: begin
        // IR is held (IRWrite low), so Opcode is still valid here
        ALUSrcA = 1'b1;
        ALUSrcB = 2'b10;
        unique case (Opcode)
          OP_ANDI: begin
            ALUOperation = ALU_AND;
            ExtOp        = 1'b0;
          end
          OP_ORI: begin
            ALUOperation = ALU_OR;
            ExtOp        = 1'b0;
          end
          default: ALUOperation = ALU_ADD;
        endcase
      end
      S_IMM_WB: RegWrite = 1'b1;
      S_JUMP: begin
        PCSrc = 2'b10;
        PCEn  = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-cycle output vectors vs
// an instruction-level reference model; honours BNE_SUPPORT_EN.
module tb_multicycle_control;

  typedef struct packed {
    logic [3:0] aluop;
    logic       pcen;
    logic [1:0] pcsrc;
    logic       iord;
    logic       memread;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       regdst;
    logic       memtoreg;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic       extop;
    logic       illegal;
  } exp_t;

  logic       clk;
  logic       reset;
  logic [5:0] Opcode;
  logic [5:0] Funct;
  logic       Zero;
  logic [3:0] ALUOperation;
  logic       PCEn;
  logic [1:0] PCSrc;
  logic       IorD, MemRead, MemWrite, IRWrite, RegWrite;
  logic       RegDst, MemtoReg, ALUSrcA, ExtOp, Illegal;
  logic [1:0] ALUSrcB;

  int checks = 0;
  int fails  = 0;

  multicycle_control dut (
    .clk(clk), .reset(reset), .Opcode(Opcode), .Funct(Funct),
    .Zero(Zero), .ALUOperation(ALUOperation), .PCEn(PCEn),
    .PCSrc(PCSrc), .IorD(IorD), .MemRead(MemRead),
    .MemWrite(MemWrite), .IRWrite(IRWrite), .RegWrite(RegWrite),
    .RegDst(RegDst), .MemtoReg(MemtoReg), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ExtOp(ExtOp), .Illegal(Illegal)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic legal(input logic [5:0] op,
                                 input logic [5:0] fn);
    if (op == 6'h00)
      return fn inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h27};
`ifdef BNE_SUPPORT_EN
    if (op == 6'h05) return 1'b1;
`endif
    return op inside {6'h23, 6'h2B, 6'h04, 6'h08, 6'h0C,
                      6'h0D, 6'h02};
  endfunction

  function automatic int ilen(input logic [5:0] op,
                              input logic [5:0] fn);
    if (!legal(op, fn)) return 2;
    if (op == 6'h23) return 5;
    if (op inside {6'h04, 6'h05, 6'h02}) return 3;
    return 4;
  endfunction

  function automatic logic [3:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return 4'b0011;
      6'h22:   return 4'b0100;
      6'h24:   return 4'b0000;
      6'h25:   return 4'b0001;
      default: return 4'b0010;
    endcase
  endfunction

  // Expected outputs for cycle c (0 = fetch) of instruction op/fn.
  function automatic exp_t model(input logic [5:0] op,
                                 input logic [5:0] fn,
                                 input int c, input logic z);
    exp_t e;
    e = '0;
    e.aluop = 4'b0011;
    e.extop = 1'b1;
    if (c == 0) begin
      e.pcen = 1; e.memread = 1; e.irwrite = 1; e.alusrcb = 2'b01;
    end else if (c == 1) begin
      e.alusrcb = 2'b11;
      e.illegal = !legal(op, fn);
    end else if (op == 6'h23 || op == 6'h2B) begin
      if (c == 2) begin
        e.alusrca = 1; e.alusrcb = 2'b10;
      end else if (op == 6'h2B) begin
        e.iord = 1; e.memwrite = 1;
      end else if (c == 3) begin
        e.iord = 1; e.memread = 1;
      end else begin
        e.regwrite = 1; e.memtoreg = 1;
      end
    end else if (op == 6'h00) begin
      if (c == 2) begin
        e.alusrca = 1; e.aluop = r_alu(fn);
      end else begin
        e.regwrite = 1; e.regdst = 1;
      end
    end else if (op == 6'h04 || op == 6'h05) begin
      e.alusrca = 1; e.aluop = 4'b0100; e.pcsrc = 2'b01;
      e.pcen = (op == 6'h04) ? z : !z;
    end else if (op == 6'h02) begin
      e.pcsrc = 2'b10; e.pcen = 1;
    end else begin
      if (c == 2) begin
        e.alusrca = 1; e.alusrcb = 2'b10;
        if (op == 6'h0C) begin e.aluop = 4'b0000; e.extop = 0; end
        if (op == 6'h0D) begin e.aluop = 4'b0001; e.extop = 0; end
      end else begin
        e.regwrite = 1;
      end
    end
    return e;
  endfunction

  function automatic exp_t observed();
    return {ALUOperation, PCEn, PCSrc, IorD, MemRead, MemWrite,
            IRWrite, RegWrite, RegDst, MemtoReg, ALUSrcA, ALUSrcB,
            ExtOp, Illegal};
  endfunction

  task automatic check(input exp_t e, input string tag);
    exp_t o;
    o = observed();
    checks++;
    assert (o === e) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, o, e);
    end
  endtask

  // zmode: 0/1 force Zero, 2 random
  task automatic step(input logic [5:0] op, input logic [5:0] fn,
                      input int c, input int zmode);
    logic z;
    z = (zmode == 2) ? 1'($urandom_range(0, 1)) : zmode[0];
    Opcode = op;
    Funct  = fn;
    Zero   = z;
    #1;
    check(model(op, fn, c, z),
          $sformatf("op%02h_fn%02h_c%0d", op, fn, c));
  endtask

  task automatic run(input logic [5:0] op, input logic [5:0] fn,
                     input int zmode);
    for (int c = 0; c < ilen(op, fn); c++) begin
      step(op, fn, c, zmode);
      @(posedge clk);
      #1;
    end
  endtask

  logic [5:0] ops [10];
  logic [5:0] fns [6];
  exp_t fetch_v;

  initial begin
    ops = '{6'h23, 6'h2B, 6'h00, 6'h04, 6'h08,
            6'h0C, 6'h0D, 6'h02, 6'h05, 6'h3F};
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h00};
    fetch_v = model(6'h00, 6'h20, 0, 1'b0);
    reset  = 1'b0;
    Opcode = 6'h00;
    Funct  = 6'h00;
    Zero   = 1'b0;
    #3;
    check(fetch_v, "reset_async");
    @(posedge clk); #1;
    check(fetch_v, "reset_hold");
    @(negedge clk);
    reset = 1'b1;

    run(6'h23, 6'h00, 2);
    run(6'h00, 6'h27, 2);
    run(6'h00, 6'h20, 2);
    run(6'h00, 6'h22, 2);
    run(6'h00, 6'h24, 2);
    run(6'h00, 6'h25, 2);
    run(6'h04, 6'h00, 1);
    run(6'h04, 6'h00, 0);
    run(6'h0D, 6'h11, 2);
    run(6'h08, 6'h11, 2);
    run(6'h0C, 6'h11, 2);
    run(6'h2B, 6'h00, 2);
    run(6'h02, 6'h00, 2);
    run(6'h3F, 6'h00, 2);
    run(6'h00, 6'h00, 2);
    run(6'h05, 6'h00, 0);
    run(6'h05, 6'h00, 1);

    // abort lw in MEMRD via async reset
    for (int c = 0; c < 4; c++) begin
      step(6'h23, 6'h00, c, 2);
      if (c < 3) begin
        @(posedge clk); #1;
      end
    end
    #2;
    reset = 1'b0;
    #1;
    check(fetch_v, "reset_mid_memrd");
    @(posedge clk); #1;
    check(fetch_v, "reset_mid_hold");
    @(negedge clk);
    reset = 1'b1;
    run(6'h2B, 6'h00, 2);
    run(6'h00, 6'h22, 2);

    for (int i = 0; i < 200; i++) begin
      logic [5:0] op, fn;
      op = ops[$urandom_range(0, 9)];
      if ($urandom_range(0, 7) == 0) op = 6'($urandom_range(0, 63));
      fn = fns[$urandom_range(0, 5)];
      if ($urandom_range(0, 7) == 0) fn = 6'($urandom_range(0, 63));
      run(op, fn, 2);
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             checks, fails);
    $finish;
  end

endmodule
